// File: rtl/dram_arbiter.sv
//------------------------------------------------------------------------------
// Module   : dram_arbiter
// Summary  : Single-port data-RAM arbiter that shares the RAM between the CPU
//            and a DMA/debug loader. The CPU has fixed priority, and a
//            starvation bound guarantees that the DMA side makes progress.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dram_arbiter #(
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk_in,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_ack,
    output logic [DW-1:0] dma_rdata,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_data,
    output logic          mem_wren,
    input  logic [DW-1:0] mem_q,
    output logic [1:0]    owner
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_RDWAIT = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    localparam logic [1:0] c_OWN_NONE = 2'b00;
    localparam logic [1:0] c_OWN_CPU  = 2'b01;
    localparam logic [1:0] c_OWN_DMA  = 2'b10;

    localparam logic [3:0] c_MAX_WAIT = 4'(MAX_WAIT);

    logic [1:0]    r_state;
    logic [1:0]    w_next_state;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [1:0]    r_owner;
    logic [DW-1:0] r_cpu_rdata;
    logic [DW-1:0] r_dma_rdata;
    logic [3:0]    r_starve_cnt;
    logic          w_any_req;
    logic          w_dma_win;

    assign w_any_req = cpu_req | dma_req;
    // DMA only overrides a pending CPU request once the CPU has used up its streak.
    assign w_dma_win = dma_req & (~cpu_req | (r_starve_cnt == c_MAX_WAIT));

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:   w_next_state = w_any_req ? c_ACCESS : c_IDLE;
            c_ACCESS: w_next_state = r_we ? c_DONE : c_RDWAIT;
            c_RDWAIT: w_next_state = c_DONE;
            c_DONE:   w_next_state = c_IDLE;
            default:  w_next_state = c_IDLE;
        endcase
    end

    // State is reset asynchronously, so mem_wren falls as soon as reset rises.
    always_comb begin
        mem_address = '0;
        mem_data    = '0;
        mem_wren    = 1'b0;
        cpu_ack     = 1'b0;
        dma_ack     = 1'b0;
        case (r_state)
            c_ACCESS: begin
                mem_address = r_addr;
                mem_data    = r_wdata;
                mem_wren    = r_we;
            end
            c_RDWAIT: begin
                mem_address = r_addr;
            end
            c_DONE: begin
                cpu_ack = (r_owner == c_OWN_CPU);
                dma_ack = (r_owner == c_OWN_DMA);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_owner      <= c_OWN_NONE;
            r_cpu_rdata  <= '0;
            r_dma_rdata  <= '0;
            r_starve_cnt <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_any_req) begin
                        if (w_dma_win) begin
                            r_we         <= dma_we;
                            r_addr       <= dma_addr;
                            r_wdata      <= dma_wdata;
                            r_owner      <= c_OWN_DMA;
                            r_starve_cnt <= '0;
                        end else begin
                            r_we    <= cpu_we;
                            r_addr  <= cpu_addr;
                            r_wdata <= cpu_wdata;
                            r_owner <= c_OWN_CPU;
                            if (!dma_req) begin
                                r_starve_cnt <= '0;
                            end else if (r_starve_cnt != c_MAX_WAIT) begin
                                r_starve_cnt <= r_starve_cnt + 4'd1;
                            end
                        end
                    end else begin
                        r_starve_cnt <= '0;
                    end
                end
                c_RDWAIT: begin
                    if (r_owner == c_OWN_CPU) begin
                        r_cpu_rdata <= mem_q;
                    end else if (r_owner == c_OWN_DMA) begin
                        r_dma_rdata <= mem_q;
                    end
                end
                c_DONE: begin
                    r_owner <= c_OWN_NONE;
                end
                default: begin
                end
            endcase
        end
    end

    assign cpu_rdata = r_cpu_rdata;
    assign dma_rdata = r_dma_rdata;
    assign owner     = r_owner;

endmodule

`default_nettype wire

// File: tb/tb_dram_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_dram_arbiter
// Summary  : Directed self-checking bench for dram_arbiter with a registered-
//            address RAM model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dram_arbiter;

    logic        clk_in = 1'b0;
    logic        reset  = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0, cpu_wdata = '0;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [15:0] dma_addr = '0, dma_wdata = '0;
    logic        dma_ack;
    logic [15:0] dma_rdata;
    logic [15:0] mem_address, mem_data, mem_q;
    logic        mem_wren;
    logic [1:0]  owner;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [15:0] ram [0:255];

    dram_arbiter #(.AW(16), .DW(16), .MAX_WAIT(4)) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_ack     (cpu_ack),
        .cpu_rdata   (cpu_rdata),
        .dma_req     (dma_req),
        .dma_we      (dma_we),
        .dma_addr    (dma_addr),
        .dma_wdata   (dma_wdata),
        .dma_ack     (dma_ack),
        .dma_rdata   (dma_rdata),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q),
        .owner       (owner)
    );

    always #10 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        cyc <= cyc + 1;
        if (mem_wren) ram[mem_address[7:0]] <= mem_data;
        mem_q <= ram[mem_address[7:0]];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk_in) begin
        if (!reset && (cpu_ack || dma_ack))
            check_eq("ack_excl", 32'(cpu_ack & dma_ack), 32'd0);
    end

    // One transaction; starts on the next falling edge and returns on the ack cycle.
    task automatic xfer(input bit is_dma, input bit we, input logic [15:0] addr,
                        input logic [15:0] wdata, output int lat, output int wren_n,
                        output logic [15:0] wren_a, output logic [1:0] own,
                        output int ack_cyc);
        @(negedge clk_in);
        if (is_dma) begin
            dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
        lat = 0; wren_n = 0; wren_a = '0; own = 2'b00; ack_cyc = 0;
        for (int k = 1; k <= 12 && lat == 0; k++) begin
            @(negedge clk_in);
            if (mem_wren) begin
                wren_n++;
                wren_a = mem_address;
            end
            if (k == 1) own = owner;
            if (is_dma ? dma_ack : cpu_ack) begin
                lat = k;
                ack_cyc = cyc;
            end
        end
    endtask

    task automatic release_req();
        @(negedge clk_in);
        cpu_req = 1'b0;
        dma_req = 1'b0;
    endtask

    int          lat, wn, ac, prev_ac;
    logic [15:0] wa;
    logic [1:0]  own;
    logic [31:0] acc;
    int          ack_log [0:9];
    int          n_acks;
    bit          saw_dma_owner;

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = '0;

        // Reset state
        @(negedge clk_in);
        @(negedge clk_in);
        check_eq("rst_outputs", {cpu_ack, dma_ack, mem_wren, owner, mem_address},
                 32'd0);
        check_eq("rst_rdata", {cpu_rdata, dma_rdata}, 32'd0);
        reset = 1'b0;

        // Idle for 20 cycles
        acc = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            acc = acc | {11'd0, mem_wren, cpu_ack, dma_ack, owner, mem_address};
        end
        check_eq("idle_quiet", acc, 32'd0);

        // CPU write then read
        xfer(1'b0, 1'b1, 16'h0010, 16'hBEEF, lat, wn, wa, own, ac);
        check_eq("cpu_wr_lat", lat, 2);
        check_eq("cpu_wr_wren_cycles", wn, 1);
        check_eq("cpu_wr_addr", {16'd0, wa}, 32'h0010);
        check_eq("cpu_wr_owner", {30'd0, own}, 32'd1);
        release_req();
        xfer(1'b0, 1'b0, 16'h0010, 16'h0000, lat, wn, wa, own, ac);
        check_eq("cpu_rd_lat", lat, 3);
        check_eq("cpu_rd_wren_cycles", wn, 0);
        check_eq("cpu_rd_data", {16'd0, cpu_rdata}, 32'hBEEF);
        release_req();
        @(negedge clk_in);
        check_eq("idle_owner", {30'd0, owner}, 32'd0);

        // Simultaneous requests: CPU first, DMA next
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 16'h1111;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0021; dma_wdata = 16'h2222;
        @(negedge clk_in);
        check_eq("sim_owner_cpu", {30'd0, owner}, 32'd1);
        lat = 0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(negedge clk_in);
            if (cpu_ack) lat = k;
        end
        check_eq("sim_cpu_ack_lat", lat, 1);
        @(negedge clk_in);
        cpu_req = 1'b0;
        lat = 0;
        saw_dma_owner = 1'b0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(negedge clk_in);
            if (owner == 2'b10) saw_dma_owner = 1'b1;
            if (dma_ack) lat = k;
        end
        check_eq("sim_dma_owner", 32'(saw_dma_owner), 32'd1);
        check_eq("sim_dma_ack_lat", lat, 2);
        release_req();

        // DMA burst of 8 writes, back-to-back
        prev_ac = 0;
        for (int i = 0; i < 8; i++) begin
            xfer(1'b1, 1'b1, 16'(i), 16'h1234, lat, wn, wa, own, ac);
            check_eq("dma_burst_lat", lat, 2);
            check_eq("dma_burst_addr", {16'd0, wa}, 32'(i));
            if (i > 0) check_eq("dma_burst_spacing", ac - prev_ac, 3);
            prev_ac = ac;
        end
        release_req();
        xfer(1'b1, 1'b0, 16'h0000, 16'h0000, lat, wn, wa, own, ac);
        check_eq("dma_rd0_lat", lat, 3);
        check_eq("dma_rd0_data", {16'd0, dma_rdata}, 32'h1234);
        release_req();
        xfer(1'b1, 1'b0, 16'h0007, 16'h0000, lat, wn, wa, own, ac);
        check_eq("dma_rd7_data", {16'd0, dma_rdata}, 32'h1234);
        check_eq("cpu_rdata_hold", {16'd0, cpu_rdata}, 32'hBEEF);
        release_req();

        // Starvation bound: both held high, expect C C C C D C C C C D
        @(negedge clk_in);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0030; cpu_wdata = 16'hAAAA;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0031; dma_wdata = 16'h5555;
        n_acks = 0;
        for (int k = 0; k < 60 && n_acks < 10; k++) begin
            @(negedge clk_in);
            if (cpu_ack) begin ack_log[n_acks] = 1; n_acks++; end
            else if (dma_ack) begin ack_log[n_acks] = 2; n_acks++; end
        end
        check_eq("starve_ack_count", n_acks, 10);
        for (int i = 0; i < n_acks; i++)
            check_eq($sformatf("starve_seq[%0d]", i), ack_log[i], (i % 5 == 4) ? 2 : 1);
        release_req();
        @(negedge clk_in);

        // Reset during the ACCESS cycle of a CPU write
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 16'hDEAD;
        @(negedge clk_in);
        check_eq("rst_mid_wren_before", 32'(mem_wren), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_eq("rst_mid_wren_async", {13'd0, mem_wren, owner, mem_address}, 32'd0);
        cpu_req = 1'b0;
        acc = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_in);
            acc = acc | {30'd0, cpu_ack, dma_ack};
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            acc = acc | {30'd0, cpu_ack, dma_ack};
        end
        check_eq("rst_mid_no_ack", acc, 32'd0);
        check_eq("rst_mid_outputs", {13'd0, mem_wren, owner, mem_address}, 32'd0);
        check_eq("rst_mid_rdata", {cpu_rdata, dma_rdata}, 32'd0);
        xfer(1'b0, 1'b0, 16'h0010, 16'h0000, lat, wn, wa, own, ac);
        check_eq("rst_mid_abandoned", {16'd0, cpu_rdata}, 32'hBEEF);
        release_req();
        @(negedge clk_in);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Owns the single port of the data RAM. Shares it between the CPU memory-access stage and an external DMA/debug requester (program/data loader).
- Runs in the 50 MHz memory clock domain. Sequences each access as arbitrate → drive RAM → capture read data → acknowledge.
- Fixed CPU priority, with a starvation bound that guarantees DMA progress.

Parameters:
- AW, 16, RAM address width in bits.
- DW, 16, RAM data width in bits.
- MAX_WAIT, 4, maximum consecutive CPU grants allowed while dma_req is pending (range 1..15).

Ports:
- clk_in  input  1  50 MHz memory clock.
- reset  input  1  asynchronous, active-high reset.
- cpu_req  input  1  CPU access request (level); held until cpu_ack.
- cpu_we  input  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr  input  AW  CPU address; stable while cpu_req is high.
- cpu_wdata  input  DW  CPU write data.
- cpu_ack  output  1  one-cycle completion pulse.
- cpu_rdata  output  DW  CPU read data, valid when cpu_ack is high; holds until the next CPU read completes.
- dma_req, dma_we, dma_addr, dma_wdata, dma_ack, dma_rdata: same widths and semantics as the cpu_* ports, for the DMA side.
- mem_address  output  AW  to RAM address.
- mem_data  output  DW  to RAM write data.
- mem_wren  output  1  to RAM write enable.
- mem_q  input  DW  RAM read data; RAM registers the address, so q is valid one clk_in cycle after the address is presented.
- owner  output  2  current owner: 00 none, 01 CPU, 10 DMA.

Behaviour:
- Reset (async): state IDLE; all outputs 0 (cpu_rdata, dma_rdata, mem_*, acks, owner); starvation counter 0.
- Reset asserted mid-access: mem_wren drops immediately, the access is abandoned, no ack is issued. The requester re-requests after reset.
- FSM states: IDLE, ACCESS, RDWAIT, DONE.
- IDLE:
  - If neither req is high, stay in IDLE.
  - Otherwise select a winner and latch its we/addr/wdata into internal registers; owner is set; go to ACCESS.
- Selection rule:
  - DMA wins if dma_req && (!cpu_req || starve_cnt == MAX_WAIT).
  - Else CPU wins.
- ACCESS (1 cycle):
  - mem_address = latched addr.
  - mem_data = latched wdata.
  - mem_wren = latched we.
  - Next state: write → DONE; read → RDWAIT.
- RDWAIT (1 cycle):
  - mem_address is still driven; mem_wren = 0.
  - At the clock edge, mem_q is captured into the owner's rdata register; go to DONE.
- DONE (1 cycle):
  - The owner's ack = 1; mem_wren = 0; next state IDLE; owner returns to 00 on entry to IDLE.
- Outputs outside ACCESS/RDWAIT: mem_address = 0, mem_data = 0, mem_wren = 0.
- Latency from the req-sampled edge in IDLE:
  - Write: ack high in the 3rd cycle (IDLE, ACCESS, DONE).
  - Read: ack high in the 4th cycle (IDLE, ACCESS, RDWAIT, DONE).
- Requester handshake:
  - The requester deasserts req in the cycle after ack.
  - A req still high when the FSM re-enters IDLE is treated as a new request (back-to-back allowed).
- Starvation counter:
  - Increments (saturating at MAX_WAIT) on each CPU grant while dma_req = 1.
  - Clears on a DMA grant, or whenever dma_req = 0 in IDLE.
- Acks are mutually exclusive. mem_wren is never high outside ACCESS.
- Request inputs change only while the corresponding req is low or in the cycle after ack. Any other change is a requester protocol violation; the arbiter uses the values latched in IDLE.

Test Plan:
- CPU write, then read:
  - cpu_req, we = 1, addr 0x0010, wdata 0xBEEF → mem_wren = 1 for exactly one cycle with mem_address = 0x0010; cpu_ack in cycle 3.
  - Then a CPU read of 0x0010 → cpu_ack in cycle 4 with cpu_rdata = 0xBEEF.
- Simultaneous requests:
  - cpu_req and dma_req both rise in the same cycle, counter 0 → CPU served first (owner = 01).
  - DMA is served in the following arbitration → owner = 10, dma_ack follows.
- Starvation (MAX_WAIT = 4): cpu_req held high continuously, dma_req held high → exactly 4 CPU acks, then one DMA grant; counter returns to 0, then CPU is served again.
- DMA loader burst: dma writes 0x1234 to addresses 0..7 back-to-back with the CPU idle → 8 dma_acks, each 3 cycles apart; a DMA readback returns the same data.
- Reset mid-write: assert reset during ACCESS of a write → mem_wren falls asynchronously, no cpu_ack; after release, state is IDLE and all outputs are 0.
- No request: both reqs low for 20 cycles → mem_wren, mem_address, owner and both acks stay 0.
